// File: rtl/ld_pkg.sv
// Shared types and defaults for the Lopez-Dahab doubling sequencer over GF(2^4).
package ld_pkg;
    localparam int GF_W = 4;
    localparam logic [GF_W:0]   DEF_POLY   = 5'b10011;
    localparam logic [GF_W-1:0] DEF_A_COEF = 4'h4;
    localparam logic [GF_W-1:0] DEF_B_COEF = 4'h1;

    typedef enum logic [3:0] {
        IDLE, S1, S2, S3, S4, S5, S6, S7, S8, S9, S10
    } state_t;
endpackage

// File: rtl/gf16_mul.sv
// Combinational GF(2^4) multiplier: carry-less 4x4 product reduced modulo POLY.
module gf16_mul
    import ld_pkg::*;
#(
    parameter logic [GF_W:0] POLY = DEF_POLY
) (
    input  logic [GF_W-1:0] i_a,
    input  logic [GF_W-1:0] i_b,
    output logic [GF_W-1:0] o_p
);
    logic [2*GF_W-2:0] w_prod;

    always_comb begin
        w_prod = '0;
        for (int i = 0; i < GF_W; i++) begin
            if (i_b[i]) w_prod = w_prod ^ ({{(GF_W-1){1'b0}}, i_a} << i);
        end
        // Fold the high terms back down from the top bit so each step clears one bit.
        for (int k = 2*GF_W-2; k >= GF_W; k--) begin
            if (w_prod[k]) w_prod = w_prod ^ ({{(GF_W-2){1'b0}}, POLY} << (k-GF_W));
        end
        o_p = w_prod[GF_W-1:0];
    end
endmodule

// File: rtl/ld_double_seq.sv
// Ten-step LD point doubler sharing one GF(2^4) multiplier.
// Optional macro LD_DOUBLE_INF_BYPASS_EN short-circuits z1=0 inputs to (1,0,0).
module ld_double_seq
    import ld_pkg::*;
#(
    parameter logic [GF_W-1:0] A_COEF = DEF_A_COEF,
    parameter logic [GF_W-1:0] B_COEF = DEF_B_COEF,
    parameter logic [GF_W:0]   POLY   = DEF_POLY
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [GF_W-1:0] x1,
    input  logic [GF_W-1:0] y1,
    input  logic [GF_W-1:0] z1,
    output logic            busy,
    output logic            done,
    output logic [GF_W-1:0] x2,
    output logic [GF_W-1:0] y2,
    output logic [GF_W-1:0] z2
);
    localparam logic [GF_W-1:0] ONE = {{(GF_W-1){1'b0}}, 1'b1};

    state_t          r_state, w_next;
    logic [GF_W-1:0] r_xl, r_yl, r_zl;
    logic [GF_W-1:0] r_t0, r_t1, r_t2, r_x, r_z;
    logic [GF_W-1:0] r_x2, r_y2, r_z2;
    logic            r_done;
    logic [GF_W-1:0] w_ma, w_mb, w_p;
    logic            w_inf;

`ifdef LD_DOUBLE_INF_BYPASS_EN
    assign w_inf = (z1 == '0);
`else
    assign w_inf = 1'b0;
`endif

    gf16_mul #(.POLY(POLY)) u_mul (
        .i_a (w_ma),
        .i_b (w_mb),
        .o_p (w_p)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_ma   = '0;
        w_mb   = '0;
        case (r_state)
            IDLE: if (start && !w_inf) w_next = S1;
            S1:  begin w_ma = r_xl;   w_mb = r_xl; w_next = S2;   end
            S2:  begin w_ma = r_zl;   w_mb = r_zl; w_next = S3;   end
            S3:  begin w_ma = r_t0;   w_mb = r_t1; w_next = S4;   end
            S4:  begin w_ma = r_t0;   w_mb = r_t0; w_next = S5;   end
            S5:  begin w_ma = r_t1;   w_mb = r_t1; w_next = S6;   end
            S6:  begin w_ma = B_COEF; w_mb = r_t1; w_next = S7;   end
            S7:  begin w_ma = r_yl;   w_mb = r_yl; w_next = S8;   end
            S8:  begin w_ma = A_COEF; w_mb = r_z;  w_next = S9;   end
            S9:  begin w_ma = r_x;    w_mb = r_t2; w_next = S10;  end
            S10: begin w_ma = r_t1;   w_mb = r_z;  w_next = IDLE; end
            default: w_next = IDLE;
        endcase
    end

    // Each step writes one product back, with its XOR terms folded in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xl <= '0; r_yl <= '0; r_zl <= '0;
            r_t0 <= '0; r_t1 <= '0; r_t2 <= '0;
            r_x  <= '0; r_z  <= '0;
            r_x2 <= '0; r_y2 <= '0; r_z2 <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_xl <= x1;
                    r_yl <= y1;
                    r_zl <= z1;
                    if (w_inf) begin
                        r_x2   <= ONE;
                        r_y2   <= '0;
                        r_z2   <= '0;
                        r_done <= 1'b1;
                    end
                end
                S1:  r_t0 <= w_p;
                S2:  r_t1 <= w_p;
                S3:  r_z  <= w_p;
                S4:  r_t0 <= w_p;
                S5:  r_t1 <= w_p;
                S6:  begin r_t1 <= w_p; r_x <= r_t0 ^ w_p; end
                S7:  r_t2 <= w_p;
                S8:  r_t2 <= r_t2 ^ w_p ^ r_t1;
                S9:  r_t2 <= w_p;
                S10: begin
                    r_x2   <= r_x;
                    r_y2   <= r_t2 ^ w_p;
                    r_z2   <= r_z;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign x2   = r_x2;
    assign y2   = r_y2;
    assign z2   = r_z2;
endmodule

// File: doc/ld_double_seq.md
Name: ld_double_seq

Overview:
Multi-cycle sequencer for Lopez-Dahab point doubling over GF(2^4), with polynomial basis and reduction polynomial x^4+x+1.
- Computes the same result as the combinational doubler: Z2=X1^2*Z1^2; X2=X1^4+b*Z1^4; Y2=b*Z1^4*Z2+X2*(a*Z2+Y1^2+b*Z1^4).
- Uses one shared GF(2^4) multiplier, time-multiplexed across ten steps, with a start/busy/done handshake.
- Sits under the scalar-multiplication controller, which issues one doubling per key bit.

Parameters:
A_COEF, 4'h4, curve coefficient a.
B_COEF, 4'h1, curve coefficient b (must be nonzero).
POLY, 5'b10011, field reduction polynomial, x^4+x+1.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  request one doubling; sampled only in IDLE.
x1  in  4  input X coordinate.
y1  in  4  input Y coordinate.
z1  in  4  input Z coordinate.
busy  out  1  high while a doubling is in progress (states S1..S10).
done  out  1  single-cycle pulse; x2/y2/z2 are valid from this cycle onward.
x2  out  4  result X, registered, held until the next completion.
y2  out  4  result Y, registered, held until the next completion.
z2  out  4  result Z, registered, held until the next completion.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, x2=y2=z2=0; temporaries T0..T2 and latched inputs cleared.
- IDLE with start=1 at an edge: latch x1/y1/z1 into XL/YL/ZL and go to S1. Inputs may change afterwards.
- Each step Sn takes one cycle and performs one multiply. Additions (XOR) are fused into the write-back of the same step.
  - S1: T0=XL*XL
  - S2: T1=ZL*ZL
  - S3: Z=T0*T1
  - S4: T0=T0*T0
  - S5: T1=T1*T1
  - S6: T1=B_COEF*T1 and X=T0^(B_COEF*T1)
  - S7: T2=YL*YL
  - S8: T2=T2^(A_COEF*Z)^T1
  - S9: T2=X*T2
  - S10: Y=T2^(T1*Z)
- End of S10: write x2/y2/z2 from X/Y/Z, return to IDLE, set done=1 for exactly one cycle.
- Latency: start accepted at edge k gives done=1 in the cycle after edge k+10 (10 cycles of busy).
- start during S1..S10 is ignored: no queueing, latched inputs unchanged.
- start asserted in the done cycle (state is IDLE) is accepted, so back-to-back throughput is one result per 11 cycles.
- rst mid-operation: abort at the next edge to the full reset state. No done is emitted and x2/y2/z2 are cleared.
- All arithmetic is 4-bit GF(2^4). No carries. Every multiply is reduced modulo POLY.
- Z1=0 (point at infinity) is computed normally unless the optional feature is enabled.

Optional Feature:
Macro LD_DOUBLE_INF_BYPASS_EN.
- Defined: IDLE with start=1 and z1=0 skips S1..S10. At the next edge x2=1, y2=0, z2=0, and done=1 in the following cycle. busy never rises.
- Undefined: z1=0 follows the normal 10-step path. Example: (2,3,0) yields (3,F,0).

Decomposition:
- Shared package ld_pkg: state enum (IDLE, S1..S10), GF_W=4, default POLY, default A_COEF and B_COEF.
- One sub-module, gf16_mul: combinational 4x4 polynomial multiply with reduction by POLY. It is instantiated once, and operand muxes are driven by state.

Test Plan:
- Reset, then start with (x1,y1,z1)=(2,3,1), a=4, b=1 -> busy for 10 cycles, done pulse, (x2,y2,z2)=(2,A,4). Outputs hold after done.
- start with z1=0, (2,3,0): with the macro undefined -> (3,F,0) after 10 cycles; with LD_DOUBLE_INF_BYPASS_EN -> (1,0,0), done one cycle after acceptance, busy stays 0.
- Pulse start again at cycles 3 and 7 of busy with different inputs -> ignored; first result (2,A,4) is unchanged and only one done pulse occurs.
- Assert start in the done cycle with (1,1,1) -> accepted immediately; second done arrives 11 cycles after the first, with the result matching the reference model.
- Assert rst at step S5 -> next cycle busy=0, done=0, outputs=0; a subsequent start with (2,3,1) yields (2,A,4).
- Random inputs over all 4096 (x1,y1,z1) combinations against a GF(2^4) software model of the formula -> all match. Separately, gf16_mul exhaustive 256 pairs, e.g. 2*7=E and 4*4=3.
